// File: rtl/tmds_decoder.sv
// Receive-side TMDS channel decoder: bit-slip alignment against control tokens,
// then per-symbol decode into pixel byte / control pair / data-enable.

module tmds_sym_decode (
  input  logic [9:0] sym_i,
  output logic       is_tok_o,
  output logic [1:0] tok_ctrl_o,
  output logic [7:0] data_o
);
  logic [7:0] x;

  always_comb begin
    is_tok_o   = 1'b1;
    tok_ctrl_o = 2'b00;
    case (sym_i)
      10'b1101010100: tok_ctrl_o = 2'b00;
      10'b0010101011: tok_ctrl_o = 2'b01;
      10'b0101010100: tok_ctrl_o = 2'b10;
      10'b1010101011: tok_ctrl_o = 2'b11;
      default:        is_tok_o   = 1'b0;
    endcase
  end

  // Undo the DC-balance inversion, then the XOR/XNOR transition chain.
  always_comb begin
    x         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = 8'h00;
    data_o[0] = x[0];
    for (int i = 1; i < 8; i++)
      data_o[i] = sym_i[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
  end
endmodule

module tmds_decoder #(
  parameter int LOCK_COUNT     = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int DROP_COUNT     = 2048
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [9:0] rawIn,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);
  localparam int IDLE_MAX = (SEARCH_TIMEOUT > DROP_COUNT) ? SEARCH_TIMEOUT : DROP_COUNT;
  localparam int RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [9:0]        raw_q, sym_q, sym_d;
  logic [19:0]       hist;
  logic [4:0]        sel;
  logic [RUN_W-1:0]  run_q, run_d, run_inc;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  logic [3:0]        offset_q, offset_d;
  logic              skip_q, skip_d;
  logic [7:0]        data_q;
  logic [1:0]        ctrl_q;
  logic              de_q;

  logic              tok;
  logic [1:0]        tok_ctrl;
  logic [7:0]        dec;

  assign hist  = {rawIn, raw_q};
  assign sel   = {1'b0, offset_q};
  assign sym_d = hist[sel +: 10];

  tmds_sym_decode u_dec (
    .sym_i      (sym_q),
    .is_tok_o   (tok),
    .tok_ctrl_o (tok_ctrl),
    .data_o     (dec)
  );

  assign run_inc  = (run_q  == RUN_W'(LOCK_COUNT)) ? run_q  : run_q  + 1'b1;
  assign idle_inc = (idle_q == IDLE_W'(IDLE_MAX))  ? idle_q : idle_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    idle_d   = idle_q;
    offset_d = offset_q;
    skip_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        // skip_q: sym_q was captured with the pre-slip offset, so ignore it.
        if (!skip_q) begin
          if (tok) begin
            run_d  = run_inc;
            idle_d = '0;
            if (run_inc == RUN_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              run_d   = '0;
            end
          end else if (idle_inc == IDLE_W'(SEARCH_TIMEOUT)) begin
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            run_d    = '0;
            idle_d   = '0;
            skip_d   = 1'b1;
          end else begin
            run_d  = '0;
            idle_d = idle_inc;
          end
        end
      end
      LOCKED: begin
        if (tok) begin
          idle_d = '0;
        end else if (idle_inc == IDLE_W'(DROP_COUNT)) begin
          state_d = SEARCH;
          run_d   = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_inc;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Outputs follow the next state so lock and the first decoded symbol share an edge.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      raw_q    <= '0;
      sym_q    <= '0;
      run_q    <= '0;
      idle_q   <= '0;
      offset_q <= '0;
      skip_q   <= 1'b0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      raw_q    <= rawIn;
      sym_q    <= sym_d;
      run_q    <= run_d;
      idle_q   <= idle_d;
      offset_q <= offset_d;
      skip_q   <= skip_d;
      if (state_d == LOCKED) begin
        if (tok) begin
          de_q   <= 1'b0;
          ctrl_q <= tok_ctrl;
          data_q <= '0;
        end else begin
          de_q   <= 1'b1;
          data_q <= dec;
        end
      end else begin
        de_q   <= 1'b0;
        ctrl_q <= '0;
        data_q <= '0;
      end
    end
  end

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign locked = (state_q == LOCKED);
  assign offset = offset_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: directed symbol streams, expected outputs
// queued by the driver and popped by a negedge monitor.

module tb_tmds_decoder;
  logic       clk_pix = 1'b0;
  logic       rst     = 1'b0;
  logic [9:0] rawIn   = '0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de, locked;
  logic [3:0] offset;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T01  = 10'b0010101011;
  localparam logic [9:0] T10  = 10'b0101010100;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] D100 = 10'h100;

  tmds_decoder dut (
    .clk_pix (clk_pix),
    .rst     (rst),
    .rawIn   (rawIn),
    .data    (data),
    .ctrl    (ctrl),
    .de      (de),
    .locked  (locked),
    .offset  (offset)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    string       name;
    logic [15:0] v;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       tag_req = 1'b0;
  logic       async_req = 1'b0;
  logic [1:0] tag_pipe = 2'b00;
  logic       line_mode = 1'b0;
  int         run_len = 0, last_run = 0, n_runs = 0, slips = 0;
  logic [3:0] prev_off = 4'd0;

  function automatic logic [15:0] pk(input logic lk, input logic d, input logic [1:0] c,
                                     input logic [7:0] dt, input logic [3:0] o);
    return {lk, d, c, dt, o};
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h ({locked,de,ctrl,data,offset} or count)", nm, act, exp_v);
    end
  endtask

  initial forever begin
    @(posedge clk_pix);
    tag_pipe = {tag_pipe[0], tag_req};
  end

  initial forever begin
    exp_t e;
    @(negedge clk_pix);
    if (tag_pipe[1] || async_req) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: output tagged but no expected entry queued");
      end else begin
        e = sbq.pop_front();
        cmp(e.name, {locked, de, ctrl, data, offset}, e.v);
      end
    end
  end

  initial forever begin
    @(negedge clk_pix);
    if (line_mode) begin
      if (de) run_len++;
      else if (run_len != 0) begin
        n_runs++;
        last_run = run_len;
        run_len  = 0;
      end
      if (offset != prev_off) begin
        slips++;
        prev_off = offset;
      end
    end
  end

  task automatic drive(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      rawIn = w;
      @(posedge clk_pix);
      #1;
    end
  endtask

  // Hold a symbol six cycles; tag the middle so the check lands mid-hold.
  task automatic check_sym(input string nm, input logic [9:0] w, input logic [15:0] ev);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      rawIn = w;
      if (i == 3) begin
        e.name = nm;
        e.v    = ev;
        sbq.push_back(e);
        tag_req = 1'b1;
      end else begin
        tag_req = 1'b0;
      end
      @(posedge clk_pix);
      #1;
    end
    tag_req = 1'b0;
  endtask

  task automatic async_chk(input string nm, input logic [15:0] ev);
    exp_t e;
    e.name = nm;
    e.v    = ev;
    sbq.push_back(e);
    async_req = 1'b1;
    @(negedge clk_pix);
    #1;
    async_req = 1'b0;
  endtask

  // 800-symbol lines with the symbol boundary 3 bits into the raw word.
  function automatic logic [9:0] line_word(input int j);
    logic [9:0] w, s;
    int n;
    w = '0;
    for (int b = 0; b < 10; b++) begin
      n = 10 * j + b - 3;
      if (n < 0) w[b] = 1'b0;
      else begin
        s    = (((n / 10) % 800) < 160) ? T00 : D100;
        w[b] = s[n % 10];
      end
    end
    return w;
  endfunction

  initial begin
    #1 rst = 1'b1;
    async_chk("reset_state", pk(0, 0, 2'b00, 8'h00, 4'd0));
    @(posedge clk_pix);
    #1 rst = 1'b0;

    drive(T00, 15);
    check_sym("lock_15_not_enough", D100, pk(0, 0, 2'b00, 8'h00, 4'd0));
    drive(T00, 16);
    check_sym("lock_16_data_100", D100, pk(1, 1, 2'b00, 8'h00, 4'd0));

    check_sym("data_2ff", 10'h2FF, pk(1, 1, 2'b00, 8'hFE, 4'd0));
    check_sym("tok_ctrl00", T00, pk(1, 0, 2'b00, 8'h00, 4'd0));
    check_sym("tok_ctrl01", T01, pk(1, 0, 2'b01, 8'h00, 4'd0));
    check_sym("tok_ctrl10", T10, pk(1, 0, 2'b10, 8'h00, 4'd0));
    check_sym("tok_ctrl11", T11, pk(1, 0, 2'b11, 8'h00, 4'd0));

    drive(D100, 2047);
    check_sym("hold_after_2047", T00, pk(1, 0, 2'b00, 8'h00, 4'd0));
    drive(D100, 2048);
    check_sym("drop_after_2048", T00, pk(0, 0, 2'b00, 8'h00, 4'd0));

    drive(D100, 1023);
    check_sym("timeout_token_wins", T00, pk(0, 0, 2'b00, 8'h00, 4'd0));
    drive(D100, 1024);
    check_sym("slip_after_1024", T00, pk(0, 0, 2'b00, 8'h00, 4'd1));

    drive(D100, 9400);
    check_sym("offset_wrap_9_to_0", D100, pk(0, 0, 2'b00, 8'h00, 4'd0));

    drive(T00, 20);
    check_sym("relock", D100, pk(1, 1, 2'b00, 8'h00, 4'd0));
    drive(D100, 4);
    rst = 1'b1;
    async_chk("reset_mid_run", pk(0, 0, 2'b00, 8'h00, 4'd0));
    drive(D100, 3);
    rst = 1'b0;

    line_mode = 1'b1;
    for (int j = 0; j < 8 * 800 + 170; j++) begin
      rawIn = line_word(j);
      @(posedge clk_pix);
      #1;
    end
    line_mode = 1'b0;
    cmp("line_slips", 16'(slips), 16'd3);
    cmp("line_offset", {12'd0, offset}, 16'd3);
    cmp("line_locked", {15'd0, locked}, 16'd1);
    cmp("line_de_run", 16'(last_run), 16'd640);
    cmp("line_run_count", 16'(n_runs), 16'd4);

    repeat (4) @(posedge clk_pix);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Per-channel TMDS symbol decoder for the video capture path: the receive-side counterpart of the DVI encoder and serializer. It takes unaligned 10-bit parallel words from an external deserializer at pixel rate and finds the symbol boundary by bit-slipping against the four TMDS control tokens. It then decodes each aligned symbol into 8-bit pixel data, 2 control bits and data-enable. The decoded outputs feed the capture logic that writes the frame buffer, one instance per channel (ch0/ch1/ch2).

## Interface
- LOCK_COUNT, 16, number of consecutive control tokens at the current offset required to declare lock.
- SEARCH_TIMEOUT, 1024, cycles without a control token before the offset slips by one bit (SEARCH only).
- DROP_COUNT, 2048, consecutive non-token symbols that drop lock (LOCKED only).
- clk_pix  input  1  pixel clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- rawIn  input  10  unaligned deserialized word, bit 0 earliest received.
- data  output  8  decoded pixel byte.
- ctrl  output  2  decoded control bits {C1,C0}.
- de  output  1  1 when the current symbol is a data symbol.
- locked  output  1  alignment lock indicator.
- offset  output  4  current bit-slip offset, 0..9.

## Operation
- Alignment window:
  - rawQ holds the previous rawIn.
  - hist[19:0] = {rawIn, rawQ}.
  - The aligned symbol is hist[offset+9:offset], registered into symQ each cycle.
- Token detection on symQ, written q[9:0]:
  - 10'b1101010100 = ctrl 00
  - 10'b0010101011 = ctrl 01
  - 10'b0101010100 = ctrl 10
  - 10'b1010101011 = ctrl 11
- Data decode:
  - x = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = x[0].
  - For i = 1..7: d[i] = q[8] ? x[i]^x[i-1] : ~(x[i]^x[i-1]).
- Counters:
  - runCnt counts consecutive tokens and saturates at LOCK_COUNT.
  - idleCnt counts cycles since the last token and saturates at max(SEARCH_TIMEOUT, DROP_COUNT).
  - Widths are $clog2(param+1).
- FSM states are SEARCH and LOCKED. Reset state is SEARCH.
- SEARCH:
  - Token on symQ: runCnt+1 and idleCnt cleared. When runCnt reaches LOCK_COUNT, go to LOCKED.
  - Non-token: runCnt cleared and idleCnt+1.
  - When idleCnt reaches SEARCH_TIMEOUT:
    - offset = (offset==9) ? 0 : offset+1.
    - runCnt and idleCnt are cleared.
- LOCKED:
  - Offset is frozen.
  - Token clears idleCnt. Non-token increments it.
  - When idleCnt reaches DROP_COUNT, go to SEARCH. The offset is retained and both counters are cleared.
- Output mapping (all outputs registered):
  - State LOCKED and token: de=0, ctrl=decoded bits, data=0.
  - State LOCKED and non-token: de=1, data=decoded byte, ctrl holds its last value.
  - State SEARCH: data=0, ctrl=0, de=0.
- Boundary conditions:
  - A token arriving in the same cycle idleCnt would hit SEARCH_TIMEOUT wins: no slip, idleCnt cleared.
  - A token arriving in the same cycle idleCnt would hit DROP_COUNT: lock is held.
  - Offset wraps 9 -> 0.
  - After a slip, the next symbol evaluated is the first one aligned at the new offset. No stale-offset symbol is counted.

## Timing
- Reset (asynchronous, immediate):
  - data=0, ctrl=0, de=0, locked=0, offset=0.
  - symQ=0, rawQ=0, counters=0, state SEARCH.
- Data latency: rawIn sampled at edge k into symQ; decoded outputs are valid after edge k+1. Constant 2-cycle latency.
- Offset update at edge k selects the new alignment for the symQ capture at edge k+1.
- locked rises on the same edge that the LOCK_COUNT-th token's outputs appear. de/ctrl are valid from that edge.
- locked falls on the edge of the DROP_COUNT-th non-token. Outputs are zero from that edge.
- Reset mid-operation discards lock and offset. Search restarts at offset 0 on the first edge after rst deasserts.

## Test plan
- Reset during a locked data run -> data=0, ctrl=0, de=0, locked=0, offset=0 asynchronously, before the next clk_pix edge.
- Aligned stream (offset 0), 20 tokens 10'b1101010100 then 10'h100 -> locked=1 with ctrl=00 at the 16th token output; data symbol yields de=1, data=8'h00.
- While locked, feed 10'h2FF -> data=8'hFE, de=1. Feed each of the four tokens -> ctrl=00/01/10/11 respectively, de=0.
- Repeating 800-symbol lines (160 tokens, 640 symbols of 10'h100) with the symbol boundary at bit 3 of {rawIn, rawQ} -> exactly 3 slips (offset 1, 2, 3), then locked=1 with offset=3, de high for 640 cycles per line.
- Locked, then 2048 consecutive 10'h100 -> locked falls on the 2048th, outputs zero, offset unchanged. 2047 non-tokens then one token -> lock held.
- SEARCH with idleCnt at SEARCH_TIMEOUT-1 when a token arrives -> no slip, offset unchanged, runCnt=1.
